// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter and its
// round-robin picker.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_MAX_BURST     = 4;
    localparam int DEF_STALL_TIMEOUT = 8;

    // Grant index width; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: the first asserted request at or after
// rr_ptr+1, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               pick_valid,
    output logic [IDX_W-1:0]   pick_idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk from the farthest offset to the nearest so the nearest match
    // is the one left standing.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = int'(rr_ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// with bounded bursts, a stall timeout and FIFO-full back-pressure.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = DEF_MAX_BURST,
    parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT,
    parameter int IDX_W         = idx_width(NUM_REQ)
) (
    input  logic                          clk_in,
    input  logic                          sreset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_trans_write,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_active,
    output logic [IDX_W-1:0]              grant_id
);

    localparam int BEAT_W  = $clog2(MAX_BURST + 1);
    localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   grant_id_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [BEAT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    logic [DATA_WIDTH-1:0] slot_data [NUM_REQ];
    logic                  gnt_valid;
    logic                  gnt_last;
    logic                  accept;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign gnt_valid = req_valid[grant_id];
    assign gnt_last  = req_last[grant_id];
    // A beat is never written in a reset cycle, even mid-burst.
    assign accept    = (state == GRANT) && gnt_valid && !fifo_full && !sreset;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid),
        .rr_ptr     (rr_ptr),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (sreset) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_id_nxt;
            rr_ptr    <= rr_ptr_nxt;
            beat_cnt  <= beat_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        grant_id_nxt     = grant_id;
        rr_ptr_nxt       = rr_ptr;
        beat_cnt_nxt     = beat_cnt;
        stall_cnt_nxt    = stall_cnt;
        req_ready        = '0;
        fifo_trans_write = 1'b0;
        fifo_data_in     = '0;
        grant_active     = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_id_nxt  = pick_idx;
                    rr_ptr_nxt    = pick_idx;
                    beat_cnt_nxt  = '0;
                    stall_cnt_nxt = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                grant_active = 1'b1;
                if (!fifo_full && !sreset) begin
                    req_ready = NUM_REQ'(1) << grant_id;
                end
                if (gnt_valid) begin
                    // A full-stalled but valid grantee is not idle.
                    stall_cnt_nxt = '0;
                    if (accept) begin
                        fifo_trans_write = 1'b1;
                        fifo_data_in     = slot_data[grant_id];
                        beat_cnt_nxt     = beat_cnt + 1'b1;
                        if (gnt_last || beat_cnt == BEAT_W'(MAX_BURST - 1)) begin
                            state_nxt = IDLE;
                        end
                    end
                end else if (stall_cnt == STALL_W'(STALL_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    stall_cnt_nxt = stall_cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: each scenario drives hand-built vectors
// and compares all outputs cycle by cycle against hand-computed values.
module tb_fifo_wr_arbiter;

    logic          clk_in;
    logic          sreset;
    logic [3:0]    req_valid;
    logic [3:0]    req_last;
    logic [127:0]  req_data;
    logic [3:0]    req_ready;
    logic          fifo_full;
    logic          fifo_trans_write;
    logic [31:0]   fifo_data_in;
    logic          grant_active;
    logic [1:0]    grant_id;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        tw;
        logic [31:0] data;
        logic [3:0]  rdy;
        logic        act;
        logic [1:0]  id;
    } obs_t;

    fifo_wr_arbiter #(
        .DATA_WIDTH    (32),
        .NUM_REQ       (4),
        .MAX_BURST     (4),
        .STALL_TIMEOUT (8)
    ) dut (
        .clk_in           (clk_in),
        .sreset           (sreset),
        .req_valid        (req_valid),
        .req_last         (req_last),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_trans_write (fifo_trans_write),
        .fifo_data_in     (fifo_data_in),
        .grant_active     (grant_active),
        .grant_id         (grant_id)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t mk(input logic tw, input logic [31:0] d, input logic [3:0] rdy,
                                input logic act, input logic [1:0] id);
        return '{tw: tw, data: d, rdy: rdy, act: act, id: id};
    endfunction

    function automatic obs_t sample();
        return '{tw: fifo_trans_write, data: fifo_data_in, rdy: req_ready,
                 act: grant_active, id: grant_id};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("tw=%b data=%h rdy=%b act=%b id=%0d", o.tw, o.data, o.rdy, o.act, o.id);
    endfunction

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        req_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        sreset    = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        next_cycle();
        sreset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t exp;
        sreset    = 1'b1;
        req_valid = 4'hF;
        req_last  = '0;
        req_data  = '1;
        fifo_full = 1'b0;
        next_cycle();
        sreset    = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 2; c++) begin
            exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
            @(negedge clk_in);
            got = sample();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset c%0d: got %s want %s", c, fmt(got), fmt(exp));
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        obs_t        got;
        obs_t        exp;
        logic [31:0] beats [3];
        beats = '{32'hA1, 32'hA2, 32'hA3};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid[2] = (c < 4);
            req_last[2]  = (c == 3);
            set_data(2, (c >= 1 && c <= 3) ? beats[c-1] : beats[0]);
            if (c == 0)      exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
            else if (c < 4)  exp = mk(1'b1, beats[c-1], 4'b0100, 1'b1, 2'd2);
            else             exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd2);
            @(negedge clk_in);
            got = sample();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL single c%0d: got %s want %s", c, fmt(got), fmt(exp));
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        obs_t       got;
        obs_t       exp;
        logic [1:0] order [5];
        logic [1:0] id;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int i = 0; i < 4; i++) set_data(i, 32'hB0 + 32'(i));
        for (int c = 0; c < 10; c++) begin
            if (c % 2 == 1) begin
                id  = order[(c-1)/2];
                exp = mk(1'b1, 32'hB0 + 32'(id), 4'(1) << id, 1'b1, id);
            end else begin
                id  = (c == 0) ? 2'd0 : order[c/2-1];
                exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, id);
            end
            @(negedge clk_in);
            got = sample();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL round_robin c%0d: got %s want %s", c, fmt(got), fmt(exp));
            end
            next_cycle();
        end
        req_valid = '0;
    endtask

    task automatic test_burst_cap();
        obs_t       got;
        obs_t       exp;
        logic       tw_tab [9];
        logic [1:0] id_tab [9];
        int         k;
        tw_tab = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        id_tab = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1};
        k = 0;
        do_reset();
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        req_last[3]  = 1'b1;
        set_data(3, 32'hD3);
        for (int c = 0; c < 9; c++) begin
            set_data(1, 32'hC1 + 32'(k));
            if (tw_tab[c])
                exp = mk(1'b1, (id_tab[c] == 2'd1) ? 32'hC1 + 32'(k) : 32'hD3,
                         4'(1) << id_tab[c], 1'b1, id_tab[c]);
            else
                exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, id_tab[c]);
            @(negedge clk_in);
            got = sample();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL burst_cap c%0d: got %s want %s", c, fmt(got), fmt(exp));
            end
            next_cycle();
            if (tw_tab[c] && id_tab[c] == 2'd1) k++;
            if (c == 6) req_valid[3] = 1'b0;
        end
        req_valid = '0;
    endtask

    // Full is held for 9 cycles, longer than the stall timeout, and must
    // neither drop the grant nor disturb the beat order.
    task automatic test_back_pressure();
        obs_t got;
        obs_t exp;
        int   k;
        logic full_now;
        k = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            full_now     = (c >= 2 && c <= 10);
            fifo_full    = full_now;
            req_valid[0] = (k < 3);
            req_last[0]  = (k == 2);
            set_data(0, 32'hE1 + 32'(k));
            if (c == 0 || c == 13)
                exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
            else if (full_now)
                exp = mk(1'b0, 32'h0, 4'b0000, 1'b1, 2'd0);
            else
                exp = mk(1'b1, 32'hE1 + 32'(k), 4'b0001, 1'b1, 2'd0);
            @(negedge clk_in);
            got = sample();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL back_pressure c%0d: got %s want %s", c, fmt(got), fmt(exp));
            end
            next_cycle();
            if (exp.tw) k++;
        end
        fifo_full = 1'b0;
        req_valid = '0;
        req_last  = '0;
    endtask

    // Four idle cycles, one full-stalled valid cycle that clears the stall
    // count, then eight idle cycles before the grant is revoked.
    task automatic test_stall_timeout();
        obs_t got;
        obs_t exp;
        do_reset();
        req_last[3] = 1'b1;
        set_data(3, 32'hD3);
        for (int c = 0; c < 18; c++) begin
            req_valid[2] = (c <= 1 || c == 6);
            req_valid[3] = (c <= 16);
            fifo_full    = (c == 6);
            set_data(2, (c <= 1) ? 32'hF1 : 32'hF2);
            if (c == 0)       exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
            else if (c == 1)  exp = mk(1'b1, 32'hF1, 4'b0100, 1'b1, 2'd2);
            else if (c == 6)  exp = mk(1'b0, 32'h0, 4'b0000, 1'b1, 2'd2);
            else if (c <= 14) exp = mk(1'b0, 32'h0, 4'b0100, 1'b1, 2'd2);
            else if (c == 15) exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd2);
            else if (c == 16) exp = mk(1'b1, 32'hD3, 4'b1000, 1'b1, 2'd3);
            else              exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd3);
            @(negedge clk_in);
            got = sample();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL stall_timeout c%0d: got %s want %s", c, fmt(got), fmt(exp));
            end
            next_cycle();
        end
        fifo_full = 1'b0;
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_reset_mid_burst();
        obs_t got;
        obs_t exp;
        int   k;
        k = 0;
        do_reset();
        req_last[0] = 1'b1;
        set_data(0, 32'h05);
        for (int c = 0; c < 7; c++) begin
            sreset       = (c == 2);
            req_valid[1] = 1'b1;
            req_valid[0] = (c >= 2 && c <= 4);
            set_data(1, 32'h11 + 32'(k));
            case (c)
                0:       exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
                1:       exp = mk(1'b1, 32'h11, 4'b0010, 1'b1, 2'd1);
                2:       exp = mk(1'b0, 32'h0, 4'b0000, 1'b1, 2'd1);
                3:       exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
                4:       exp = mk(1'b1, 32'h05, 4'b0001, 1'b1, 2'd0);
                5:       exp = mk(1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
                default: exp = mk(1'b1, 32'h12, 4'b0010, 1'b1, 2'd1);
            endcase
            @(negedge clk_in);
            got = sample();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_mid_burst c%0d: got %s want %s", c, fmt(got), fmt(exp));
            end
            next_cycle();
            if (exp.tw && exp.id == 2'd1) k++;
        end
        sreset    = 1'b0;
        req_valid = '0;
        req_last  = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_back_pressure();
        test_stall_timeout();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
